// File: rtl/oak8m_rambus_arbiter_if.sv
// Wishbone signal bundle for oak8m_rambus_arbiter: two requesting masters
// (CPU pmem path and host/LA debug path) plus the single OpenRAM rambus port.
// The "slave" modport is the arbiter's view; "master" is the view of whatever
// drives the masters and models the RAM.
interface oak8m_rambus_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  localparam int SEL_W = DATA_W / 8;

  // master 0: CPU pmem SRAM path
  logic              m0_cyc_i;
  logic              m0_stb_i;
  logic              m0_we_i;
  logic [SEL_W-1:0]  m0_sel_i;
  logic [ADDR_W-1:0] m0_addr_i;
  logic [DATA_W-1:0] m0_dat_i;
  logic              m0_ack_o;
  logic              m0_err_o;
  logic [DATA_W-1:0] m0_dat_o;

  // master 1: host/LA debug path
  logic              m1_cyc_i;
  logic              m1_stb_i;
  logic              m1_we_i;
  logic [SEL_W-1:0]  m1_sel_i;
  logic [ADDR_W-1:0] m1_addr_i;
  logic [DATA_W-1:0] m1_dat_i;
  logic              m1_ack_o;
  logic              m1_err_o;
  logic [DATA_W-1:0] m1_dat_o;

  // OpenRAM rambus port
  logic              rambus_wb_clk_o;
  logic              rambus_wb_rst_o;
  logic              rambus_wb_cyc_o;
  logic              rambus_wb_stb_o;
  logic              rambus_wb_we_o;
  logic [SEL_W-1:0]  rambus_wb_sel_o;
  logic [ADDR_W-1:0] rambus_wb_addr_o;
  logic [DATA_W-1:0] rambus_wb_dat_o;
  logic              rambus_wb_ack_i;
  logic [DATA_W-1:0] rambus_wb_dat_i;

  // one-hot owner status {OWN1, OWN0}
  logic [1:0]        grant_o;

  modport slave (
    input  m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_addr_i, m0_dat_i,
    output m0_ack_o, m0_err_o, m0_dat_o,
    input  m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_addr_i, m1_dat_i,
    output m1_ack_o, m1_err_o, m1_dat_o,
    output rambus_wb_clk_o, rambus_wb_rst_o,
    output rambus_wb_cyc_o, rambus_wb_stb_o, rambus_wb_we_o,
    output rambus_wb_sel_o, rambus_wb_addr_o, rambus_wb_dat_o,
    input  rambus_wb_ack_i, rambus_wb_dat_i,
    output grant_o
  );

  modport master (
    output m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_addr_i, m0_dat_i,
    input  m0_ack_o, m0_err_o, m0_dat_o,
    output m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_addr_i, m1_dat_i,
    input  m1_ack_o, m1_err_o, m1_dat_o,
    input  rambus_wb_clk_o, rambus_wb_rst_o,
    input  rambus_wb_cyc_o, rambus_wb_stb_o, rambus_wb_we_o,
    input  rambus_wb_sel_o, rambus_wb_addr_o, rambus_wb_dat_o,
    output rambus_wb_ack_i, rambus_wb_dat_i,
    input  grant_o
  );
endinterface

// File: rtl/oak8m_rambus_arbiter.sv
// oak8m_rambus_arbiter: two-master Wishbone arbiter in front of the single
// OpenRAM rambus port. Master 0 is the CPU pmem path, master 1 the host/LA
// debug path. The grant is registered (one cycle of arbitration latency),
// held for the whole Wishbone cycle, and always released through one IDLE
// cycle so a waiting master can win the next round-robin decision.
//
// Optional feature: define OAK8M_RAMARB_TIMEOUT_EN to add an ack-wait
// watchdog (TIMEOUT_CYCLES) that aborts the owner's cycle with an err pulse.
// Without it, mN_err_o is tied low and an owner waits for ack indefinitely.
module oak8m_rambus_arbiter #(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 32
`ifdef OAK8M_RAMARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  oak8m_rambus_arbiter_if.slave  bus
);
  localparam int SEL_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              last;
  logic              last_nxt;
  logic              rst_meta;
  logic              rst_sync_n;

  logic              own0;
  logic              own1;
  logic              req0;
  logic              req1;
  logic              own_cyc;
  logic              own_stb;
  logic              own_we;
  logic [SEL_W-1:0]  own_sel;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_dat;
  logic              tmo;

  // Reset synchronizer: asserts together with reset, releases on the second clk edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_meta   <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      rst_meta   <= 1'b1;
      rst_sync_n <= rst_meta;
    end
  end

  assign own0 = (state == OWN0);
  assign own1 = (state == OWN1);
  assign req0 = bus.m0_cyc_i & bus.m0_stb_i;
  assign req1 = bus.m1_cyc_i & bus.m1_stb_i;

`ifdef OAK8M_RAMARB_TIMEOUT_EN
  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;

  // Ack-wait counter: held clear while idle so it starts at zero on every grant
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      wait_cnt <= '0;
    end else if (state == IDLE) begin
      wait_cnt <= '0;
    end else if (!bus.rambus_wb_ack_i) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // The TIMEOUT_CYCLES-th owned cycle without ack aborts; an ack in that cycle wins
  assign tmo = own_cyc & ~bus.rambus_wb_ack_i & (wait_cnt == CNT_LAST);
`else
  assign tmo = 1'b0;
`endif

  // Owner/last-served registers
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  // Round-robin arbitration and cycle-end detection
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          state_nxt = last ? OWN0 : OWN1;
        end else if (req0) begin
          state_nxt = OWN0;
        end else if (req1) begin
          state_nxt = OWN1;
        end
      end
      OWN0: begin
        if (!bus.m0_cyc_i) begin
          state_nxt = IDLE;
        end else if (bus.rambus_wb_ack_i || tmo) begin
          state_nxt = IDLE;
          last_nxt  = 1'b0;
        end
      end
      OWN1: begin
        if (!bus.m1_cyc_i) begin
          state_nxt = IDLE;
        end else if (bus.rambus_wb_ack_i || tmo) begin
          state_nxt = IDLE;
          last_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Owner's request signals; everything is zero when nobody owns the bus
  always_comb begin
    own_cyc  = 1'b0;
    own_stb  = 1'b0;
    own_we   = 1'b0;
    own_sel  = '0;
    own_addr = '0;
    own_dat  = '0;
    if (own0) begin
      own_cyc  = bus.m0_cyc_i;
      own_stb  = bus.m0_stb_i;
      own_we   = bus.m0_we_i;
      own_sel  = bus.m0_sel_i;
      own_addr = bus.m0_addr_i;
      own_dat  = bus.m0_dat_i;
    end else if (own1) begin
      own_cyc  = bus.m1_cyc_i;
      own_stb  = bus.m1_stb_i;
      own_we   = bus.m1_we_i;
      own_sel  = bus.m1_sel_i;
      own_addr = bus.m1_addr_i;
      own_dat  = bus.m1_dat_i;
    end
  end

  // stb follows cyc so an abort (or timeout) removes both in the same cycle
  assign bus.rambus_wb_clk_o  = clk;
  assign bus.rambus_wb_rst_o  = ~reset;
  assign bus.rambus_wb_cyc_o  = own_cyc & ~tmo;
  assign bus.rambus_wb_stb_o  = own_cyc & own_stb & ~tmo;
  assign bus.rambus_wb_we_o   = own_we;
  assign bus.rambus_wb_sel_o  = own_sel;
  assign bus.rambus_wb_addr_o = own_addr;
  assign bus.rambus_wb_dat_o  = own_dat;

  // Ack only reaches the owner, and only while it still holds cyc
  assign bus.m0_ack_o = bus.rambus_wb_ack_i & own0 & bus.m0_cyc_i;
  assign bus.m1_ack_o = bus.rambus_wb_ack_i & own1 & bus.m1_cyc_i;
  assign bus.m0_err_o = tmo & own0;
  assign bus.m1_err_o = tmo & own1;
  assign bus.m0_dat_o = own0 ? bus.rambus_wb_dat_i : '0;
  assign bus.m1_dat_o = own1 ? bus.rambus_wb_dat_i : '0;

  assign bus.grant_o  = {own1, own0};
endmodule

// File: tb/tb_oak8m_rambus_arbiter.sv
// Bench for oak8m_rambus_arbiter: directed scenarios followed by a randomized
// run against a transaction-level model of the two masters and the RAM.
`timescale 1ns/1ps
module tb_oak8m_rambus_arbiter;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int SEL_W  = DATA_W / 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic              m_cyc  [2];
  logic              m_stb  [2];
  logic              m_we   [2];
  logic [SEL_W-1:0]  m_sel  [2];
  logic [ADDR_W-1:0] m_addr [2];
  logic [DATA_W-1:0] m_dat  [2];

  int          mown;
  int          mlast;
  int          waitc;
  int          grants;
  int          own_n;
  int          err_at;
  bit          act      [2];
  bit          prev_ack [2];
  bit          exp_ack  [2];
  bit          newtx;
  bit          ack;
  bit          r0;
  bit          r1;
  bit          nxt1;
  logic [1:0]  g;
  logic [1:0]  exp_g;
  logic [DATA_W-1:0] rdat;
  logic [48:0] exp_bus;

  oak8m_rambus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  oak8m_rambus_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
`ifdef OAK8M_RAMARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [48:0] bus_vec();
    return {bus.rambus_wb_cyc_o, bus.rambus_wb_stb_o, bus.rambus_wb_we_o,
            bus.rambus_wb_sel_o, bus.rambus_wb_addr_o, bus.rambus_wb_dat_o};
  endfunction

  function automatic logic [48:0] master_vec(input int n);
    return {m_cyc[n], m_cyc[n] & m_stb[n], m_we[n], m_sel[n], m_addr[n], m_dat[n]};
  endfunction

  task automatic drive_masters();
    bus.m0_cyc_i  = m_cyc[0];
    bus.m0_stb_i  = m_stb[0];
    bus.m0_we_i   = m_we[0];
    bus.m0_sel_i  = m_sel[0];
    bus.m0_addr_i = m_addr[0];
    bus.m0_dat_i  = m_dat[0];
    bus.m1_cyc_i  = m_cyc[1];
    bus.m1_stb_i  = m_stb[1];
    bus.m1_we_i   = m_we[1];
    bus.m1_sel_i  = m_sel[1];
    bus.m1_addr_i = m_addr[1];
    bus.m1_dat_i  = m_dat[1];
  endtask

  task automatic set_m(input int n, input logic cyc, input logic stb, input logic we,
                       input logic [SEL_W-1:0] sel, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] dat);
    m_cyc[n]  = cyc;
    m_stb[n]  = stb;
    m_we[n]   = we;
    m_sel[n]  = sel;
    m_addr[n] = addr;
    m_dat[n]  = dat;
    drive_masters();
  endtask

  task automatic set_ram(input logic a, input logic [DATA_W-1:0] d);
    bus.rambus_wb_ack_i = a;
    bus.rambus_wb_dat_i = d;
  endtask

  task automatic idle_inputs();
    set_m(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    set_m(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    set_ram(1'b0, '0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;

    // ---------------- reset state ----------------
    step();
    chk("rst_grant", 64'(bus.grant_o), 64'd0);
    chk("rst_bus", 64'(bus_vec()), 64'd0);
    chk("rst_ram_rst", 64'(bus.rambus_wb_rst_o), 64'd1);
    chk("rst_ack_err", 64'({bus.m0_ack_o, bus.m1_ack_o, bus.m0_err_o, bus.m1_err_o}), 64'd0);
    chk("rst_mdat", 64'({bus.m0_dat_o, bus.m1_dat_o}), 64'd0);
    chk("wb_clk_hi", 64'(bus.rambus_wb_clk_o), 64'(clk));
    @(negedge clk);
    #1;
    chk("wb_clk_lo", 64'(bus.rambus_wb_clk_o), 64'(clk));
    step();
    reset = 1'b1;
    repeat (3) step();
    chk("ram_rst_released", 64'(bus.rambus_wb_rst_o), 64'd0);

    // ---------------- T1: single m0 read ----------------
    set_m(0, 1'b1, 1'b1, 1'b0, 4'hF, 10'h005, '0);
    settle();
    chk("T1_idle_grant", 64'(bus.grant_o), 64'd0);
    chk("T1_idle_cyc", 64'(bus.rambus_wb_cyc_o), 64'd0);
    step();
    chk("T1_grant", 64'(bus.grant_o), 64'b01);
    chk("T1_bus", 64'(bus_vec()), 64'({1'b1, 1'b1, 1'b0, 4'hF, 10'h005, 32'h0}));
    step();
    chk("T1_noack", 64'({bus.m0_ack_o, bus.m1_ack_o}), 64'd0);
    step();
    set_ram(1'b1, 32'hDEADBEEF);
    settle();
    chk("T1_ack", 64'({bus.m0_ack_o, bus.m1_ack_o}), 64'b10);
    chk("T1_m0_dat", 64'(bus.m0_dat_o), 64'hDEADBEEF);
    chk("T1_m1_dat", 64'(bus.m1_dat_o), 64'd0);
    step();
    idle_inputs();
    settle();
    chk("T1_release", 64'(bus.grant_o), 64'd0);

    // ---------------- T2: simultaneous request after reset ----------------
    do_reset();
    set_m(0, 1'b1, 1'b1, 1'b0, 4'hF, 10'h011, '0);
    set_m(1, 1'b1, 1'b1, 1'b0, 4'hF, 10'h100, '0);
    settle();
    chk("T2_idle", 64'(bus.grant_o), 64'd0);
    step();
    chk("T2_first_m0", 64'(bus.grant_o), 64'b01);
    set_ram(1'b1, 32'h11111111);
    settle();
    chk("T2_ack_m0", 64'({bus.m0_ack_o, bus.m1_ack_o}), 64'b10);
    step();
    set_m(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    set_ram(1'b0, '0);
    settle();
    chk("T2_gap", 64'(bus.grant_o), 64'd0);
    step();
    chk("T2_then_m1", 64'(bus.grant_o), 64'b10);
    set_ram(1'b1, 32'h22222222);
    settle();
    chk("T2_ack_m1", 64'({bus.m0_ack_o, bus.m1_ack_o}), 64'b01);
    chk("T2_m1_dat", 64'(bus.m1_dat_o), 64'h22222222);
    chk("T2_m0_dat", 64'(bus.m0_dat_o), 64'd0);
    step();
    idle_inputs();
    settle();
    chk("T2_release", 64'(bus.grant_o), 64'd0);

    // ---------------- T3: both masters back-to-back ----------------
    set_m(0, 1'b1, 1'b1, 1'b0, 4'hF, 10'h020, '0);
    set_m(1, 1'b1, 1'b1, 1'b1, 4'hF, 10'h021, 32'h12345678);
    set_ram(1'b1, 32'h33333333);
    grants = 0;
    nxt1   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) step();
      settle();
      g = bus.grant_o;
      if (g != 2'b00) begin
        chk("T3_order", 64'(g), nxt1 ? 64'b10 : 64'b01);
        chk("T3_ack_owner", 64'({bus.m1_ack_o, bus.m0_ack_o}), 64'(g));
        nxt1   = ~nxt1;
        grants = grants + 1;
      end
    end
    chk("T3_grant_count", 64'(grants), 64'd8);
    step();
    idle_inputs();
    settle();

    // ---------------- T4: m1 write, m0 toggling ----------------
    set_m(1, 1'b1, 1'b1, 1'b1, 4'b0011, 10'h3FF, 32'h0000A55A);
    step();
    set_m(0, 1'b1, 1'b1, 1'b0, 4'hF, 10'h123, 32'hFFFFFFFF);
    settle();
    chk("T4_grant", 64'(bus.grant_o), 64'b10);
    chk("T4_bus_a", 64'(bus_vec()), 64'({1'b1, 1'b1, 1'b1, 4'b0011, 10'h3FF, 32'h0000A55A}));
    step();
    set_m(0, 1'b0, 1'b1, 1'b1, 4'h5, 10'h0AA, 32'h55555555);
    settle();
    chk("T4_bus_b", 64'(bus_vec()), 64'({1'b1, 1'b1, 1'b1, 4'b0011, 10'h3FF, 32'h0000A55A}));
    set_m(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    set_ram(1'b1, 32'h0);
    settle();
    chk("T4_ack", 64'({bus.m0_ack_o, bus.m1_ack_o}), 64'b01);
    step();
    idle_inputs();
    settle();

    // ---------------- T5: abort, late ack ----------------
    set_m(0, 1'b1, 1'b1, 1'b0, 4'hF, 10'h010, '0);
    step();
    chk("T5_grant", 64'(bus.grant_o), 64'b01);
    chk("T5_cyc_up", 64'(bus.rambus_wb_cyc_o), 64'd1);
    step();
    set_m(0, 1'b0, 1'b0, 1'b0, 4'hF, 10'h010, '0);
    settle();
    chk("T5_drop_same_cycle", 64'({bus.rambus_wb_cyc_o, bus.rambus_wb_stb_o}), 64'd0);
    step();
    set_ram(1'b1, 32'h0000BAD1);
    settle();
    chk("T5_idle", 64'(bus.grant_o), 64'd0);
    chk("T5_late_ack", 64'({bus.m0_ack_o, bus.m1_ack_o}), 64'd0);
    chk("T5_late_dat", 64'({bus.m0_dat_o, bus.m1_dat_o}), 64'd0);
    step();
    idle_inputs();
    set_m(0, 1'b1, 1'b1, 1'b0, 4'hF, 10'h012, '0);
    step();
    set_m(0, 1'b0, 1'b1, 1'b0, 4'hF, 10'h012, '0);
    set_ram(1'b1, 32'h0000BAD2);
    settle();
    chk("T5_drop_with_ack", 64'({bus.m0_ack_o, bus.m1_ack_o, bus.rambus_wb_cyc_o}), 64'd0);
    step();
    idle_inputs();
    settle();
    chk("T5_back_idle", 64'(bus.grant_o), 64'd0);

    // ---------------- T6: reset mid-transaction / timeout ----------------
    set_m(0, 1'b1, 1'b1, 1'b0, 4'hF, 10'h030, '0);
    step();
    chk("T6_grant", 64'(bus.grant_o), 64'b01);
    reset = 1'b0;
    #1;
    chk("T6_async_bus", 64'(bus_vec()), 64'd0);
    chk("T6_async_grant", 64'(bus.grant_o), 64'd0);
    chk("T6_ram_rst", 64'(bus.rambus_wb_rst_o), 64'd1);
    do_reset();

    set_m(0, 1'b1, 1'b1, 1'b0, 4'hF, 10'h031, '0);
    own_n  = 0;
    err_at = 0;
`ifdef OAK8M_RAMARB_TIMEOUT_EN
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus.grant_o == 2'b01) own_n = own_n + 1;
      if (bus.m0_err_o === 1'b1) begin
        err_at = own_n;
        chk("T6_tmo_cyc_drop", 64'(bus.rambus_wb_cyc_o), 64'd0);
        break;
      end
    end
    chk("T6_tmo_cycle", 64'(err_at), 64'd8);
    set_m(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    step();
    chk("T6_tmo_idle", 64'(bus.grant_o), 64'd0);
    chk("T6_err_pulse", 64'(bus.m0_err_o), 64'd0);
`else
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus.m0_err_o !== 1'b0) err_at = err_at + 1;
      if (bus.grant_o == 2'b01) own_n = own_n + 1;
    end
    chk("T6_no_err", 64'(err_at), 64'd0);
    chk("T6_waits_forever", 64'(own_n), 64'd20);
`endif

    // ---------------- randomized run against model ----------------
    do_reset();
    mown  = -1;
    mlast = 1;
    waitc = 0;
    for (int n = 0; n < 2; n++) begin
      act[n]      = 1'b0;
      prev_ack[n] = 1'b0;
    end
    for (int c = 0; c < 400; c++) begin
      for (int n = 0; n < 2; n++) begin
        newtx = 1'b0;
        if (act[n] && prev_ack[n]) begin
          act[n] = ($urandom_range(1) == 0);
          newtx  = act[n];
        end else if (!act[n]) begin
          act[n] = ($urandom_range(2) == 0);
          newtx  = act[n];
        end
        if (newtx) begin
          set_m(n, 1'b1, 1'b1, 1'($urandom), 4'($urandom), 10'($urandom), 32'($urandom));
        end else if (!act[n]) begin
          set_m(n, 1'b0, 1'($urandom), 1'($urandom), 4'($urandom), 10'($urandom), 32'($urandom));
        end
      end
      if (mown >= 0 && m_cyc[mown]) ack = (waitc >= 4) || ($urandom_range(2) == 0);
      else ack = ($urandom_range(7) == 0);
      rdat = 32'($urandom);
      set_ram(ack, rdat);
      settle();

      exp_g   = (mown == 0) ? 2'b01 : (mown == 1) ? 2'b10 : 2'b00;
      exp_bus = (mown >= 0) ? master_vec(mown) : '0;
      for (int n = 0; n < 2; n++) exp_ack[n] = ack && (mown == n) && m_cyc[n];
      chk("R_grant", 64'(bus.grant_o), 64'(exp_g));
      chk("R_bus", 64'(bus_vec()), 64'(exp_bus));
      chk("R_ack", 64'({bus.m0_ack_o, bus.m1_ack_o}), 64'({exp_ack[0], exp_ack[1]}));
      chk("R_m0_dat", 64'(bus.m0_dat_o), (mown == 0) ? 64'(rdat) : 64'd0);
      chk("R_m1_dat", 64'(bus.m1_dat_o), (mown == 1) ? 64'(rdat) : 64'd0);
      chk("R_err", 64'({bus.m0_err_o, bus.m1_err_o}), 64'd0);

      for (int n = 0; n < 2; n++) prev_ack[n] = exp_ack[n];
      if (mown < 0) begin
        r0 = m_cyc[0] & m_stb[0];
        r1 = m_cyc[1] & m_stb[1];
        if (r0 && r1) mown = 1 - mlast;
        else if (r0) mown = 0;
        else if (r1) mown = 1;
        waitc = 0;
      end else if (!m_cyc[mown]) begin
        mown = -1;
      end else if (ack) begin
        mlast = mown;
        mown  = -1;
      end else begin
        waitc = waitc + 1;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
